// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage widths, state encoding and buffer entry type
package riscv_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } buf_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous instruction FIFO with flush taking priority over push
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  buf_entry_t             push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output buf_entry_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    buf_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_entry;
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing, single-credit imem requests, redirect/flush and fault handling
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [XLEN-1:0]    instr_pc,
    output logic               fetch_fault
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;

    fetch_state_t    state, state_nx;
    logic [XLEN-1:0] pc, pc_nx;
    logic [XLEN-1:0] tag;
    logic            outstanding, outstanding_nx;
    logic            accept, push, pop, stale, req_ok;
    logic [CRD_W-1:0] credit_used;
    buf_entry_t      head;
    logic            buf_full, buf_empty;
    logic [CNT_W-1:0] buf_count;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry ('{pc: tag, instr: imem_resp_data}),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .full       (buf_full),
        .empty      (buf_empty),
        .count      (buf_count)
    );

    assign instr_valid = !reset && !buf_empty;
    assign instruction = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign pop         = instr_valid && instr_ready;
    assign fetch_fault = !reset && (state == FAULT);

    // An arriving response still occupies a credit: it moves from in-flight into the buffer.
    assign credit_used = CRD_W'(buf_count) + CRD_W'(outstanding) - CRD_W'(pop);
    assign req_ok = (state == RUN) && (!outstanding || imem_resp_valid)
                  && (credit_used < CRD_W'(BUF_DEPTH));
    assign imem_req_valid = !reset && req_ok;
    assign imem_addr      = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign push  = imem_resp_valid && outstanding && (state == RUN) && !redirect_valid
                 && (!buf_full || pop);
    assign stale = accept || (outstanding && !imem_resp_valid);

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        outstanding_nx = outstanding;
        if (accept) begin
            pc_nx          = pc + PC_STEP;
            outstanding_nx = 1'b1;
        end else if (imem_resp_valid) begin
            outstanding_nx = 1'b0;
        end
        if (redirect_valid) begin
            pc_nx = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) state_nx = FAULT;
            else if (stale)                state_nx = DRAIN;
            else                           state_nx = RUN;
        end else if (state == DRAIN && imem_resp_valid) begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            outstanding <= 1'b0;
            tag         <= '0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            outstanding <= outstanding_nx;
            if (accept) tag <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_ready = 1'b0;
    logic [31:0] instruction, instr_pc;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];

    int          tests = 0, fails = 0, cyc = 0, epoch = 0;
    logic [31:0] exp_fetch_pc = RST_PC;
    logic        m_fault = 1'b0;
    int          lat_min = 1, lat_max = 1, rdy_pct = 100, dec_pct = 100;
    logic        nx_reset = 1'b0, nx_redirect = 1'b0, spur = 1'b0;
    logic [31:0] nx_redirect_pc = '0;
    logic        s_req_valid, s_instr_valid, s_fault, s_acc, s_pop;
    logic [31:0] s_addr, s_instr_pc, s_instruction;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        logic resp_now, pop_m, stale, exp_rv;
        int   occ;
        req_t e;
        @(negedge clock);
        reset = nx_reset;
        if (nx_reset) mem_q.delete();
        resp_now = (mem_q.size() > 0) && (mem_q[0].due == cyc);
        imem_resp_valid = resp_now || spur;
        imem_resp_data  = resp_now ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        imem_req_ready  = !nx_reset && ($urandom_range(99) < rdy_pct);
        instr_ready     = $urandom_range(99) < dec_pct;
        redirect_valid  = nx_redirect;
        redirect_pc     = nx_redirect_pc;
        spur = 1'b0;
        #1;
        s_req_valid   = imem_req_valid;
        s_addr        = imem_addr;
        s_instr_valid = instr_valid;
        s_instr_pc    = instr_pc;
        s_instruction = instruction;
        s_fault       = fetch_fault;
        s_acc = 1'b0;
        s_pop = 1'b0;
        if (nx_reset) begin
            check("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            buf_q.delete();
            epoch++;
            exp_fetch_pc = RST_PC;
            m_fault = 1'b0;
            spur = 1'b1;
        end else begin
            pop_m = (buf_q.size() > 0) && instr_ready;
            stale = 1'b0;
            foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale = 1'b1;
            occ = buf_q.size() - (pop_m ? 1 : 0) + mem_q.size();
            exp_rv = !m_fault && !stale && (mem_q.size() == 0 || resp_now) && (occ < DEPTH);
            check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (imem_req_valid) check("req_addr", imem_addr, exp_fetch_pc);
            check("instr_valid", 32'(instr_valid), 32'(buf_q.size() > 0));
            if (buf_q.size() > 0) begin
                check("instr_pc", instr_pc, buf_q[0]);
                check("instruction", instruction, mem_word(buf_q[0]));
            end
            check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
            s_pop = pop_m;
            if (pop_m) void'(buf_q.pop_front());
            if (resp_now) begin
                e = mem_q.pop_front();
                if (e.epoch == epoch && !m_fault) buf_q.push_back(e.addr);
            end
            s_acc = imem_req_valid && imem_req_ready;
            if (s_acc) begin
                mem_q.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min)),
                                  epoch: epoch});
                exp_fetch_pc += 32'd4;
                acc_log.push_back(imem_addr);
                acc_cyc.push_back(cyc);
            end
            if (redirect_valid) begin
                buf_q.delete();
                epoch++;
                exp_fetch_pc = redirect_pc;
                m_fault = (redirect_pc[1:0] != 2'b00);
            end
        end
        nx_reset = 1'b0;
        nx_redirect = 1'b0;
        @(posedge clock);
        cyc++;
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        nx_reset = 1'b1;
        step();
    endtask

    task automatic redirect_to(input logic [31:0] target);
        nx_redirect = 1'b1;
        nx_redirect_pc = target;
        step();
    endtask

    task automatic wait_pop(input string tag, output logic [31:0] pc);
        logic seen = 1'b0;
        pc = '0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (s_pop) begin
                seen = 1'b1;
                pc = s_instr_pc;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        int r = $urandom_range(99);
        if (r < 10)      t = 32'h1000 + ($urandom_range(255) << 2) + $urandom_range(3, 1);
        else if (r < 15) t = 32'hFFFF_FFFC - ($urandom_range(1) << 2);
        else             t = 32'h1000 + ($urandom_range(1023) << 2);
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held, first_pc;
        logic        found;
        int          r;

        // Streaming from reset with single-cycle memory.
        do_reset();
        acc_log.delete();
        acc_cyc.delete();
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 0) begin
                check("post_rst_instr_pc", s_instr_pc, 32'd0);
                check("post_rst_instruction", s_instruction, 32'd0);
                check("post_rst_fault", 32'(s_fault), 32'd0);
                check("post_rst_addr", s_addr, RST_PC);
            end
            if (i >= 2) check("stream_valid", 32'(s_instr_valid), 32'd1);
        end
        check("first_req_count", 32'(acc_log.size() >= 3), 32'd1);
        if (acc_log.size() >= 3) begin
            check("first_req0", acc_log[0], 32'h100);
            check("first_req1", acc_log[1], 32'h104);
            check("first_req2", acc_log[2], 32'h108);
            check("req_back_to_back", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
        end

        // Decode stalled: buffer fills to two and fetch stops at 0x108.
        do_reset();
        dec_pct = 0;
        stepn(6);
        check("stall_instr_valid", 32'(s_instr_valid), 32'd1);
        check("stall_req_valid", 32'(s_req_valid), 32'd0);
        check("stall_addr", s_addr, 32'h108);
        check("stall_head_pc", s_instr_pc, 32'h100);
        dec_pct = 100;
        stepn(12);

        // Memory not ready: address held, pc not advanced.
        rdy_pct = 0;
        step();
        held = s_addr;
        check("hold_req_valid", 32'(s_req_valid), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_addr", s_addr, held);
            check("hold_req_valid", 32'(s_req_valid), 32'd1);
        end
        rdy_pct = 100;
        step();
        check("hold_release_acc", 32'(s_acc), 32'd1);
        check("hold_release_addr", acc_log[$], held);
        stepn(4);

        // Redirect while the 0x108 response is still in flight.
        do_reset();
        lat_min = 3;
        lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (s_acc && acc_log[$] == 32'h108) found = 1'b1;
        end
        check("saw_req_0x108", 32'(found), 32'd1);
        redirect_to(32'h200);
        step();
        check("flush_empty", 32'(s_instr_valid), 32'd0);
        wait_pop("pop_after_redirect", first_pc);
        check("first_pc_0x200", first_pc, 32'h200);

        // Misaligned target faults; an aligned redirect recovers.
        redirect_to(32'h202);
        for (int i = 0; i < 5; i++) begin
            step();
            check("fault_set", 32'(s_fault), 32'd1);
            check("fault_no_req", 32'(s_req_valid), 32'd0);
        end
        redirect_to(32'h300);
        step();
        check("fault_clear", 32'(s_fault), 32'd0);
        wait_pop("pop_after_fault", first_pc);
        check("first_pc_0x300", first_pc, 32'h300);

        // Address wrap at the top of the space, then reset mid-stream.
        lat_min = 1;
        lat_max = 2;
        redirect_to(32'hFFFF_FFFC);
        acc_log.delete();
        for (int i = 0; i < 40 && acc_log.size() < 2; i++) step();
        check("wrap_req_count", 32'(acc_log.size() >= 2), 32'd1);
        if (acc_log.size() >= 2) begin
            check("wrap_req0", acc_log[0], 32'hFFFF_FFFC);
            check("wrap_req1", acc_log[1], 32'h0000_0000);
        end
        stepn(4);
        do_reset();
        acc_log.delete();
        step();
        check("midrst_instr_valid", 32'(s_instr_valid), 32'd0);
        check("midrst_instr_pc", s_instr_pc, 32'd0);
        check("midrst_instruction", s_instruction, 32'd0);
        check("midrst_fault", 32'(s_fault), 32'd0);
        check("midrst_addr", s_addr, RST_PC);
        for (int i = 0; i < 10 && acc_log.size() == 0; i++) step();
        check("midrst_refetch", acc_log.size() > 0 ? acc_log[0] : 32'hFFFF_FFFF, RST_PC);

        // Random traffic, redirects and resets against the scoreboard.
        lat_min = 1;
        lat_max = 3;
        rdy_pct = 75;
        dec_pct = 65;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(999);
            if (r < 4) begin
                nx_reset = 1'b1;
            end else if (r < 50) begin
                nx_redirect = 1'b1;
                nx_redirect_pc = rand_target();
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
